mem_bus_ram: RTL
================

Name: mem_bus_ram

Overview:
- Parametrised single-port RAM with a req/ack bus handshake and configurable wait states.
- Successor to the fixed 16x12 instruction/data memory.
- Sits between the CPU control unit and program/data storage; the CPU issues one read or write per handshake.
- Read data is registered and held, replacing the old combinational tri-state output.

Parameters:
DATA_W, 16, data word width in bits.
ADDR_W, 12, address width in bits.
DEPTH, 4096, number of implemented words; legal range 1..2^ADDR_W.
WAIT_STATES, 1, extra cycles inserted before the access; legal range 0..15.

Ports:
clk     input   1       system clock, all state updates on rising edge.
rst     input   1       asynchronous, active-high reset.
req     input   1       transaction request; held by requester until it samples ack=1.
we      input   1       1 = write, 0 = read; sampled at acceptance.
addr    input   ADDR_W  word address; sampled at acceptance.
wdata   input   DATA_W  write data; sampled at acceptance.
ack     output  1       one-cycle completion pulse.
rdata   output  DATA_W  registered read data; holds last completed read.
busy    output  1       transaction in progress.
err     output  1       range error flag, valid with ack (see Optional Feature).

Behaviour:
- Reset (async, active-high):
  - state=IDLE; ack=0, busy=0, err=0, rdata=0; wait counter=0.
  - RAM contents are not reset.
- States: IDLE, WAIT, ACCESS.
- IDLE:
  - If ack=1: clear ack and err, ignore req, stay IDLE (recovery cycle).
  - Else, if req=1: latch we/addr/wdata, set busy=1, load counter=WAIT_STATES. Go to WAIT if WAIT_STATES>0, else ACCESS.
- WAIT:
  - Decrement the counter each edge.
  - When the counter reaches 1, go to ACCESS on that edge.
  - Stays in WAIT exactly WAIT_STATES edges.
- ACCESS, on the edge leaving it:
  - Write: RAM[addr_latched] <= wdata_latched.
  - Read: rdata <= RAM[addr_latched].
  - Set ack=1, busy=0; go to IDLE.
- Timing, with acceptance at edge T0:
  - ack rises at edge T0+WAIT_STATES+1 and is high for exactly one cycle.
  - The next request is accepted no earlier than T0+WAIT_STATES+3.
  - busy is high from T0 until the ack edge.
- req, we, addr and wdata changes after acceptance are ignored until IDLE.
- req held high continuously produces back-to-back transactions at the minimum period, WAIT_STATES+3.
- rdata changes only on a completed read; writes leave it unchanged.
- Reset mid-transaction (WAIT or ACCESS before its edge):
  - Aborts the transaction; no RAM write occurs.
  - ack never pulses.
- Out-of-range address (addr >= DEPTH):
  - No RAM write.
  - A read returns rdata=0.
  - Still acks normally.

Optional Feature:
- MEM_RANGE_CHECK_EN defined:
  - err=1 in the same cycle as ack for any out-of-range access, cleared with ack.
  - Data-side behaviour is as above.
- Not defined:
  - err tied to 0.
  - No comparison logic beyond write suppression and the zero read.

Test Plan:
- WAIT_STATES=1, reset, write 0x2002 to 0x000 → busy high 2 cycles; ack one cycle at T0+2; next accept no earlier than T0+4.
- Read 0x000 after the above → rdata=0x2002 at the ack edge; rdata holds 0x2002 through a subsequent write of 0x1003 to 0x001.
- Write 0x0007 to 0x002, then change addr to 0x003 and wdata to 0xFFFF the cycle after acceptance → reading 0x002 gives 0x0007; 0x003 is unchanged.
- Write 0x0005 to 0x003, then start a write of 0xBEEF to 0x003 and pulse rst during WAIT → ack stays 0, outputs return to reset values, a read of 0x003 returns 0x0005.
- WAIT_STATES=0, req held high with reads of 0x000 → ack pulses every 3 cycles, rdata=0x2002 each time.
- DEPTH=3000, write 0x1234 to 0xFFF then read 0xFFF → rdata=0 with ack. err=1 with MEM_RANGE_CHECK_EN defined, err=0 without.

Source files
------------

// File: rtl/mem_bus_ram_if.sv
// Request/acknowledge bus between the CPU control unit and mem_bus_ram.
// master = requester (CPU side), slave = memory side.
interface mem_bus_ram_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              err;

  modport master (output req, we, addr, wdata, input ack, rdata, busy, err);
  modport slave  (input req, we, addr, wdata, output ack, rdata, busy, err);
endinterface

// File: rtl/mem_bus_ram.sv
// Single-port RAM behind a req/ack handshake with WAIT_STATES cycles before each access.
// Optional MEM_RANGE_CHECK_EN: raise err alongside ack for accesses at or beyond DEPTH.
module mem_bus_ram #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 4096,
  parameter int WAIT_STATES = 1
) (
  input  logic          clk,
  input  logic          rst,
  mem_bus_ram_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      WS_L    = 4'(WAIT_STATES);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_L);
  endfunction

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_ack;
  logic              r_busy;
  logic [DATA_W-1:0] r_mem [0:DEPTH-1];

  logic w_in_range;
  logic w_mem_wr;

  assign w_in_range = in_range(r_addr);
  // rst gates the write so a reset held across the ACCESS edge cannot commit data
  assign w_mem_wr   = (r_state == S_ACCESS) && r_we && w_in_range && !rst;

`ifdef MEM_RANGE_CHECK_EN
  logic r_err;
  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.ack   = r_ack;
  assign bus.busy  = r_busy;
  assign bus.rdata = r_rdata;

  // Storage array; deliberately not reset
  always_ff @(posedge clk) begin
    if (w_mem_wr) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  // Handshake FSM with registered ack/busy/err/rdata
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
`ifdef MEM_RANGE_CHECK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_ack) begin
            // recovery cycle: a pending req is not accepted here
            r_ack <= 1'b0;
`ifdef MEM_RANGE_CHECK_EN
            r_err <= 1'b0;
`endif
          end else if (bus.req) begin
            r_we    <= bus.we;
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
            r_busy  <= 1'b1;
            r_cnt   <= WS_L;
            r_state <= (WS_L != 4'd0) ? S_WAIT : S_ACCESS;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!r_we) begin
            r_rdata <= w_in_range ? r_mem[r_addr] : '0;
          end
          r_ack   <= 1'b1;
          r_busy  <= 1'b0;
`ifdef MEM_RANGE_CHECK_EN
          r_err   <= !w_in_range;
`endif
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
